// File: rtl/un_striping_nlane_pkg.sv
// Shared constants and helpers for the N-lane unstriper.
package un_striping_pkg;

    localparam int unsigned NUM_LANES_DEF = 2;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned DEPTH_DEF     = 4;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned x = value - 1; x > 0; x = x >> 1) begin
            result++;
        end
        return result;
    endfunction

    // LSB position of lane `lane` inside the packed lane_in bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/un_striping_nlane_if.sv
// Lane-side and merged-side signals of the unstriper, bundled with master/slave views.
interface un_striping_nlane_if
    import un_striping_pkg::*;
#(
    parameter int unsigned NUM_LANES = NUM_LANES_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF
);
    localparam int unsigned SEL_W = clog2(NUM_LANES);

    logic [NUM_LANES-1:0]        valid_in;
    logic [NUM_LANES*DATA_W-1:0] lane_in;
    logic [DATA_W-1:0]           data_out;
    logic                        valid_out;
    logic [SEL_W-1:0]            lane_sel;
    logic [NUM_LANES-1:0]        overflow;
    logic                        idle;

    modport master (
        output valid_in, lane_in,
        input  data_out, valid_out, lane_sel, overflow, idle
    );

    modport slave (
        input  valid_in, lane_in,
        output data_out, valid_out, lane_sel, overflow, idle
    );

endinterface

// File: rtl/un_striping_nlane_lane_fifo.sv
// Per-lane FIFO with combinational head; absorbs inter-lane skew up to DEPTH words.
module lane_fifo
    import un_striping_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);
    localparam int unsigned PTR_W = clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers alone decide what is valid.
    always_ff @(posedge clk_2f) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PTR_W + 1)'(DEPTH));

endmodule

// File: rtl/un_striping_nlane.sv
// N-lane round-robin unstriper on clk_2f. Optional drop counter: define UNSTRIPE_DROP_CNT_EN.
module un_striping_nlane
    import un_striping_pkg::*;
#(
    parameter int unsigned NUM_LANES = NUM_LANES_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF
) (
    input  logic                 clk_2f,
    input  logic                 reset,
    un_striping_nlane_if.slave   bus
`ifdef UNSTRIPE_DROP_CNT_EN
    ,
    output logic [7:0]           drop_count
`endif
);
    localparam int unsigned      SEL_W     = clog2(NUM_LANES);
    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(NUM_LANES - 1);

    logic [NUM_LANES-1:0] empty;
    logic [NUM_LANES-1:0] full;
    logic [NUM_LANES-1:0] pop;
    logic [NUM_LANES-1:0] accept;
    logic [NUM_LANES-1:0] drop;
    logic [DATA_W-1:0]    head [NUM_LANES];

    logic [DATA_W-1:0]    data_out;
    logic                 valid_out;
    logic [SEL_W-1:0]     lane_sel;
    logic [NUM_LANES-1:0] overflow;
    logic                 sel_ready;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        // A full FIFO still accepts when its head leaves on the same edge.
        assign pop[k]    = (lane_sel == SEL_W'(k)) && !empty[k];
        assign accept[k] = bus.valid_in[k] && (!full[k] || pop[k]);
        assign drop[k]   = bus.valid_in[k] && !accept[k];

        lane_fifo #(
            .DATA_W(DATA_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_2f(clk_2f),
            .reset (reset),
            .push  (accept[k]),
            .pop   (pop[k]),
            .din   (bus.lane_in[lane_lsb(k, DATA_W) +: DATA_W]),
            .dout  (head[k]),
            .empty (empty[k]),
            .full  (full[k])
        );
    end

    assign sel_ready = |pop;

    // Selected lane empty: stall on it rather than skip, keeping strict order.
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            lane_sel  <= '0;
            overflow  <= '0;
        end else begin
            overflow <= overflow | drop;
            if (sel_ready) begin
                data_out  <= head[lane_sel];
                valid_out <= 1'b1;
                lane_sel  <= (lane_sel == LAST_LANE) ? '0 : lane_sel + SEL_W'(1);
            end else begin
                valid_out <= 1'b0;
            end
        end
    end

    assign bus.data_out  = data_out;
    assign bus.valid_out = valid_out;
    assign bus.lane_sel  = lane_sel;
    assign bus.overflow  = overflow;
    assign bus.idle      = (&empty) && !valid_out;

`ifdef UNSTRIPE_DROP_CNT_EN
    int unsigned drop_total;
    logic [7:0]  drop_next;

    always_comb begin
        drop_total = 32'(drop_count);
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            drop_total = drop_total + 32'(drop[i]);
        end
        drop_next = (drop_total > 32'd255) ? 8'hFF : drop_total[7:0];
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) drop_count <= '0;
        else       drop_count <= drop_next;
    end
`endif

endmodule

// File: doc/un_striping_nlane.md
Name: un_striping_nlane

Overview:
- Parametrised N-lane unstriper. Merges NUM_LANES striped lanes back into one word stream in strict round-robin order: lane 0, 1, …, N-1, 0, …
- Each lane has its own FIFO, so inter-lane skew of up to DEPTH words is absorbed without losing order.
- Sits on the clk_2f domain, after the lane receivers and before the byte un-striping/serial stages.

Parameters:
- NUM_LANES, 2, number of input lanes (>=2, any integer).
- DATA_W, 32, width of each lane word and of the output word.
- DEPTH, 4, per-lane FIFO depth (power of 2, >=2).

Ports:
- clk_2f  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  NUM_LANES  per-lane word-valid strobe; bit k belongs to lane k.
- lane_in  input  NUM_LANES*DATA_W  packed lane words; lane k occupies [k*DATA_W +: DATA_W].
- data_out  output  DATA_W  merged word, registered.
- valid_out  output  1  data_out is valid this cycle.
- lane_sel  output  clog2(NUM_LANES)  lane currently expected next (round-robin pointer).
- overflow  output  NUM_LANES  sticky per-lane drop flag.
- idle  output  1  high when all FIFOs are empty and valid_out=0.

Behaviour:
- Reset is asynchronous and active-high; clock is clk_2f.
- While reset=1:
  - data_out=0, valid_out=0, lane_sel=0, overflow=0, idle=1.
  - All FIFO pointers and occupancy counters are cleared; buffered words are discarded.
  - Asserting reset mid-operation clears everything immediately, without waiting for a clock edge.
- Push (each lane k, each edge):
  - If valid_in[k]=1 and (FIFO k not full OR FIFO k is being popped this edge), the word is written.
  - Otherwise the word is dropped and overflow[k] is set to 1.
  - overflow[k] stays set until reset.
- Pop/merge (each edge):
  - If FIFO[lane_sel] is non-empty: data_out <= head of FIFO[lane_sel], valid_out <= 1, lane_sel <= (lane_sel == NUM_LANES-1) ? 0 : lane_sel+1.
  - Else: valid_out <= 0, data_out holds its previous value, lane_sel holds. The lane is never skipped, so strict order is preserved.
- Latency: a word sampled at edge E on the currently selected lane with an empty FIFO appears on data_out after edge E+1, i.e. one cycle later.
- Throughput: up to 1 output word per cycle. Aggregate input above that rate is absorbed by the FIFOs until DEPTH is reached, then drops (flagged by overflow).
- Simultaneous push and pop on the same FIFO: occupancy is unchanged and the push is accepted even when the FIFO is full.
- FIFO read/write pointers wrap modulo DEPTH. Occupancy counter width is clog2(DEPTH)+1.
- idle is combinational from the occupancy counters and valid_out.

Optional Feature:
- Macro UNSTRIPE_DROP_CNT_EN.
- Defined: adds output drop_count [7:0].
  - Counts every rejected word across all lanes (adds popcount of the drops each cycle).
  - Saturates at 255.
  - Cleared by reset.
- Undefined: port and counter are absent; overflow flags are unaffected either way.

Decomposition:
- Package un_striping_pkg holds:
  - a clog2 function;
  - default constants for NUM_LANES, DATA_W and DEPTH;
  - the lane-slice helper for the packed lane_in bus.
- One sub-module, lane_fifo:
  - parametrised DATA_W/DEPTH;
  - ports push, pop, din, dout, empty, full;
  - async active-high reset.
- The top level instantiates NUM_LANES copies of lane_fifo under a generate loop and adds the round-robin pointer and output register.

Test Plan:
- Reset: hold reset=1 with random valid_in/lane_in -> data_out=0, valid_out=0, lane_sel=0, overflow=0, idle=1 throughout.
- In-order, N=2:
  - Stimulus: lane0=FFFFFFFF and lane1=EEEEEEEE valid on the same cycle, then lane0=DDDDDDDD and lane1=CCCCCCCC.
  - Response: data_out FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC on four consecutive cycles, valid_out=1.
- Skew, N=2:
  - Stimulus: lane0=00000003 valid at cycle 0; lane1=00000004 valid at cycle 3.
  - Response: 00000003 at cycle 1; valid_out=0 at cycles 2-3 with lane_sel=1 held; 00000004 at cycle 4.
- Overflow, DEPTH=4, N=2:
  - Stimulus: lane1 idle; lane0 presents words 1..6 on consecutive cycles.
  - Response: output 1, then a stall waiting on lane1; words 2-5 buffered; word 6 dropped; overflow=2'b01.
- Reset mid-operation: with 3 words buffered, pulse reset between clock edges -> outputs clear immediately; after release, the first output comes from new lane-0 data.
- N=4 wrap: lanes 0-3 present A0,A1,A2,A3 then B0..B3 -> output A0,A1,A2,A3,B0,B1,B2,B3 with lane_sel sequence 0,1,2,3,0…; with UNSTRIPE_DROP_CNT_EN, the overflow case gives drop_count=1.
